// File: rtl/wb_boot_sequencer_if.sv
// Bundles the image stream and Wishbone B3 master signals of the boot sequencer.
// The master modport is the sequencer's view; slave is the memory/stream-source side.
interface wb_boot_sequencer_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [DW-1:0]   s_data_i;
    logic            s_valid_i;
    logic            s_last_i;
    logic            s_ready_o;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic            wbm_we_o;
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic [2:0]      wbm_cti_o;
    logic [1:0]      wbm_bte_o;
    logic            wbm_ack_i;
    logic            wbm_err_i;

    modport master (
        input  s_data_i, s_valid_i, s_last_i, wbm_ack_i, wbm_err_i,
        output s_ready_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o
    );

    modport slave (
        output s_data_i, s_valid_i, s_last_i, wbm_ack_i, wbm_err_i,
        input  s_ready_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o
    );
endinterface

// File: rtl/wb_boot_sequencer.sv
// Boot sequencer: holds downstream resets, optionally streams an image into memory over
// Wishbone, then releases the reset domains one at a time.
module wb_boot_sequencer #(
    parameter int unsigned     AW          = 32,
    parameter int unsigned     DW          = 32,
    parameter logic [AW-1:0]   BASE_ADDR   = '0,
    parameter int unsigned     MAX_WORDS   = 4096,
    parameter int unsigned     NUM_RST     = 2,
    parameter int unsigned     RST_HOLD    = 16,
    parameter int unsigned     RST_STAGGER = 4,
    localparam int unsigned    WCW         = $clog2(MAX_WORDS + 1)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               load_en_i,
    wb_boot_sequencer_if.master bus,
    output logic [NUM_RST-1:0] rst_o,
    output logic [WCW-1:0]     words_o,
    output logic               done_o,
    output logic               trunc_o,
    output logic               err_o
);
    localparam int unsigned   REL_LAST = (NUM_RST - 1) * RST_STAGGER;
    localparam int unsigned   CNT_MAX  = (RST_HOLD > REL_LAST) ? RST_HOLD : REL_LAST;
    localparam int unsigned   CW       = $clog2(CNT_MAX + 1);
    localparam logic [AW-1:0] STEP     = AW'(DW / 8);

    typedef enum logic [2:0] {StHold, StLoadWait, StLoadWr, StRelease, StRun, StError} state_e;

    state_e               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [WCW-1:0]       r_words, w_words_nxt;
    logic [DW-1:0]        r_data, w_data_nxt;
    logic                 r_last, w_last_nxt;
    logic [AW-1:0]        r_adr, w_adr_nxt;
    logic                 r_cyc, w_cyc_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_trunc, w_trunc_nxt;
    logic [NUM_RST-1:0]   r_rst, w_rst_nxt;

    logic                 w_accept;
    logic [WCW-1:0]       w_words_inc;

    assign w_accept    = r_ready & bus.s_valid_i;
    assign w_words_inc = r_words + 1'b1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= StHold;
            r_cnt   <= '0;
            r_words <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_adr   <= '0;
            r_cyc   <= 1'b0;
            r_ready <= 1'b0;
            r_trunc <= 1'b0;
            r_rst   <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_words <= w_words_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_adr   <= w_adr_nxt;
            r_cyc   <= w_cyc_nxt;
            r_ready <= w_ready_nxt;
            r_trunc <= w_trunc_nxt;
            r_rst   <= w_rst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StHold: begin
                if (r_cnt == CW'(RST_HOLD - 1)) begin
                    w_state_nxt = load_en_i ? StLoadWait : StRelease;
                end
            end
            StLoadWait: begin
                if (w_accept) w_state_nxt = StLoadWr;
            end
            StLoadWr: begin
                // err takes priority over a simultaneous ack
                if (bus.wbm_err_i) begin
                    w_state_nxt = StError;
                end else if (bus.wbm_ack_i) begin
                    if (r_last || (w_words_inc == WCW'(MAX_WORDS))) w_state_nxt = StRelease;
                    else                                             w_state_nxt = StLoadWait;
                end
            end
            StRelease: begin
                if (r_cnt == CW'(REL_LAST)) w_state_nxt = StRun;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        w_cnt_nxt   = '0;
        w_words_nxt = r_words;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_adr_nxt   = r_adr;
        w_trunc_nxt = r_trunc;
        w_rst_nxt   = r_rst;
        w_ready_nxt = (w_state_nxt == StLoadWait);
        w_cyc_nxt   = (w_state_nxt == StLoadWr);
        if ((r_state == StHold || r_state == StRelease) && w_state_nxt == r_state) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        case (r_state)
            StLoadWait: begin
                if (w_accept) begin
                    w_data_nxt = bus.s_data_i;
                    w_last_nxt = bus.s_last_i;
                    w_adr_nxt  = BASE_ADDR + AW'(r_words) * STEP;
                end
            end
            StLoadWr: begin
                if (bus.wbm_ack_i && !bus.wbm_err_i) begin
                    w_words_nxt = w_words_inc;
                    if (!r_last && w_words_inc == WCW'(MAX_WORDS)) w_trunc_nxt = 1'b1;
                end
            end
            StRelease: begin
                for (int k = 0; k < int'(NUM_RST); k++) begin
                    if (r_cnt == CW'(k * RST_STAGGER)) w_rst_nxt[k] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.s_ready_o = r_ready;
    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_dat_o = r_data;
    assign bus.wbm_sel_o = '1;
    assign bus.wbm_we_o  = r_cyc;
    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_cti_o = 3'b000;
    assign bus.wbm_bte_o = 2'b00;

    assign rst_o   = r_rst;
    assign words_o = r_words;
    assign done_o  = (r_state == StRun);
    assign err_o   = (r_state == StError);
    assign trunc_o = r_trunc;
endmodule

// File: tb/tb_wb_boot_sequencer.sv
// Directed bench for wb_boot_sequencer (MAX_WORDS=4) with a latency/error-injecting
// Wishbone slave that logs every acknowledged write.
module tb_wb_boot_sequencer;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        load_en_i;
    logic [1:0]  rst_o;
    logic [2:0]  words_o;
    logic        done_o, trunc_o, err_o;

    wb_boot_sequencer_if #(.AW(32), .DW(32)) bus ();

    wb_boot_sequencer #(
        .AW(32), .DW(32), .BASE_ADDR(32'h0), .MAX_WORDS(4),
        .NUM_RST(2), .RST_HOLD(16), .RST_STAGGER(4)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .load_en_i (load_en_i),
        .bus       (bus),
        .rst_o     (rst_o),
        .words_o   (words_o),
        .done_o    (done_o),
        .trunc_o   (trunc_o),
        .err_o     (err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_vec = 0;
    int n_miss = 0;

    // Slave model state
    int          lat = 0;
    int          err_word = -1;
    logic        ack_r = 1'b0, err_r = 1'b0;
    int          cnt = 0;
    bit          busy = 0;
    logic [31:0] adr0, dat0;
    int          wr_cnt = 0, n_log = 0, starts = 0, unstable = 0, bus_bad = 0;
    logic [31:0] log_adr [16];
    logic [31:0] log_dat [16];
    logic [31:0] stim [8];

    assign bus.wbm_ack_i = ack_r;
    assign bus.wbm_err_i = err_r;

    always @(posedge wb_clk_i) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o && !ack_r) begin
            if (!busy) begin
                busy   <= 1;
                adr0   <= bus.wbm_adr_o;
                dat0   <= bus.wbm_dat_o;
                starts <= starts + 1;
            end else if (bus.wbm_adr_o != adr0 || bus.wbm_dat_o != dat0) begin
                unstable <= unstable + 1;
            end
            if (bus.wbm_sel_o != 4'hF || !bus.wbm_we_o || bus.wbm_cti_o != 3'b000 ||
                bus.wbm_bte_o != 2'b00) bus_bad <= bus_bad + 1;
            if (cnt >= lat) begin
                ack_r  <= 1'b1;
                wr_cnt <= wr_cnt + 1;
                if (wr_cnt == err_word) begin
                    err_r <= 1'b1;
                end else if (n_log < 16) begin
                    log_adr[n_log] <= bus.wbm_adr_o;
                    log_dat[n_log] <= bus.wbm_dat_o;
                    n_log <= n_log + 1;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            cnt   <= 0;
            busy  <= 0;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_slave();
        wr_cnt = 0; n_log = 0; starts = 0; unstable = 0; bus_bad = 0;
    endtask

    task automatic apply_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        clear_slave();
        wb_rst_i = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle, input int last_idx, input int bound,
                        output int accepted);
        int i = 0;
        int c = 0;
        accepted = 0;
        while (i < n && c < bound) begin
            @(negedge wb_clk_i);
            bus.s_valid_i = toggle ? ((c % 2) == 0) : 1'b1;
            bus.s_data_i  = bus.s_valid_i ? stim[i] : 32'hDEAD_DEAD;
            bus.s_last_i  = bus.s_valid_i && (i == last_idx);
            if (bus.s_valid_i && bus.s_ready_o) begin
                i++;
                accepted++;
            end
            c++;
        end
        @(negedge wb_clk_i);
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int gap);
        int r0 = -1;
        int dn = -1;
        for (int e = 0; e < bound && dn < 0; e++) begin
            @(posedge wb_clk_i);
            #1;
            if (r0 < 0 && rst_o[0] == 1'b0) r0 = e;
            if (done_o) dn = e;
        end
        gap = (dn < 0) ? -1 : dn - r0;
    endtask

    initial begin
        int r0, r1, dn, acc, gap;
        wb_rst_i = 1'b1;
        load_en_i = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_last_i = 1'b0;
        bus.s_data_i = '0;

        // Test 1: reset values, then no-load staggered release timing
        repeat (3) @(negedge wb_clk_i);
        check_val("rst_rst_o", rst_o, 2'b11);
        check_val("rst_cyc", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.s_ready_o}, 3'b000);
        check_val("rst_words", words_o, 0);
        check_val("rst_flags", {done_o, trunc_o, err_o}, 3'b000);
        wb_rst_i = 1'b0;
        r0 = -1; r1 = -1; dn = -1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge wb_clk_i);
            #1;
            if (r0 < 0 && !rst_o[0]) r0 = e;
            if (r1 < 0 && !rst_o[1]) r1 = e;
            if (dn < 0 && done_o) dn = e;
        end
        check_val("t1_rst0_fall", r0, 17);
        check_val("t1_rst1_fall", r1, 21);
        check_val("t1_done_edge", dn, 21);
        check_val("t1_words", words_o, 0);
        check_val("t1_no_cyc", starts, 0);

        // Test 2: 3-word load, 1-cycle ack
        load_en_i = 1'b1;
        stim[0] = 32'hA; stim[1] = 32'hB; stim[2] = 32'hC;
        apply_reset();
        fork
            feed(3, 1'b0, 2, 100, acc);
            wait_done(300, gap);
        join
        check_val("t2_done", done_o, 1);
        check_val("t2_words", words_o, 3);
        check_val("t2_trunc", trunc_o, 0);
        check_val("t2_rst_o", rst_o, 2'b00);
        check_val("t2_gap", gap, 4);
        check_val("t2_nwr", n_log, 3);
        check_val("t2_busbad", bus_bad, 0);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t2_adr%0d", i), log_adr[i], 32'(i * 4));
            check_val($sformatf("t2_dat%0d", i), log_dat[i], 32'hA + 32'(i));
        end

        // Test 3: 6 words, no last, truncated at MAX_WORDS=4
        for (int i = 0; i < 6; i++) stim[i] = 32'h100 + 32'(i);
        apply_reset();
        fork
            feed(6, 1'b0, -1, 120, acc);
            wait_done(300, gap);
        join
        check_val("t3_accepted", acc, 4);
        check_val("t3_nwr", n_log, 4);
        check_val("t3_trunc", trunc_o, 1);
        check_val("t3_words", words_o, 4);
        check_val("t3_done", done_o, 1);
        check_val("t3_ready", bus.s_ready_o, 0);
        check_val("t3_adr3", log_adr[3], 32'hC);
        check_val("t3_dat3", log_dat[3], 32'h103);

        // Test 4: 5-cycle slave wait, toggling valid, last on the 4th (=MAX) word
        lat = 5;
        stim[0] = 32'h1234_5678; stim[1] = 32'hCAFE_F00D;
        stim[2] = 32'h0BAD_BEEF; stim[3] = 32'h5A5A_A5A5;
        apply_reset();
        fork
            feed(4, 1'b1, 3, 200, acc);
            wait_done(400, gap);
        join
        check_val("t4_nwr", n_log, 4);
        check_val("t4_strobes", starts, 4);
        check_val("t4_unstable", unstable, 0);
        check_val("t4_words", words_o, 4);
        check_val("t4_trunc", trunc_o, 0);
        check_val("t4_done", done_o, 1);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t4_adr%0d", i), log_adr[i], 32'(i * 4));
            check_val($sformatf("t4_dat%0d", i), log_dat[i], stim[i]);
        end

        // Test 5: ack and err together on word 2
        lat = 0;
        err_word = 1;
        for (int i = 0; i < 3; i++) stim[i] = 32'h200 + 32'(i);
        apply_reset();
        feed(3, 1'b0, 2, 60, acc);
        repeat (40) @(posedge wb_clk_i);
        #1;
        check_val("t5_accepted", acc, 2);
        check_val("t5_err", err_o, 1);
        check_val("t5_words", words_o, 1);
        check_val("t5_rst_o", rst_o, 2'b11);
        check_val("t5_done", done_o, 0);
        check_val("t5_nwr", n_log, 1);
        err_word = -1;

        // Test 6: reset pulse mid-write, then a clean reload
        lat = 8;
        apply_reset();
        @(negedge wb_clk_i);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 32'h77;
        bus.s_last_i  = 1'b0;
        dn = 0;
        for (int e = 0; e < 40 && dn == 0; e++) begin
            @(posedge wb_clk_i);
            #1;
            if (bus.wbm_cyc_o) dn = 1;
        end
        check_val("t6_cyc_seen", dn, 1);
        @(negedge wb_clk_i);
        bus.s_valid_i = 1'b0;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check_val("t6_cyc_drop", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b00);
        check_val("t6_rst_o", rst_o, 2'b11);
        @(negedge wb_clk_i);
        lat = 0;
        clear_slave();
        wb_rst_i = 1'b0;
        stim[0] = 32'h11; stim[1] = 32'h22; stim[2] = 32'h33;
        fork
            feed(3, 1'b0, 2, 100, acc);
            wait_done(300, gap);
        join
        check_val("t6_done", done_o, 1);
        check_val("t6_words", words_o, 3);
        check_val("t6_nwr", n_log, 3);
        check_val("t6_dat0", log_dat[0], 32'h11);
        check_val("t6_dat2", log_dat[2], 32'h33);
        check_val("t6_adr2", log_adr[2], 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
